// File: rtl/hex_line_parser_pkg.sv
// hex_line_parser_pkg: ASCII constants, byte classes and parser states shared by the hex line parser
package hex_line_parser_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        CLS_HEX,
        CLS_TERM,
        CLS_SPACE,
        CLS_BAD
    } byte_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DISCARD,
        ST_EMIT
    } state_t;

    function automatic byte_class_t classify(input logic [7:0] b);
        if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return CLS_HEX;
        if (b == ASCII_CR || b == ASCII_LF)
            return CLS_TERM;
        if (b == ASCII_SP)
            return CLS_SPACE;
        return CLS_BAD;
    endfunction

endpackage

// File: rtl/ascii_to_hex.sv
// ascii_to_hex: converts an ASCII hex digit to its 4-bit value, 0 for anything else
module ascii_to_hex (
    input  logic [7:0] ascii,
    output logic [3:0] nibble
);

    // '0'-'9' map directly; 'A'-'F' and 'a'-'f' share low bits 1..6, offset by 9
    always_comb begin
        nibble = (ascii >= 8'h30 && ascii <= 8'h39) ? ascii[3:0] :
                 ((ascii >= 8'h41 && ascii <= 8'h46) || (ascii >= 8'h61 && ascii <= 8'h66)) ? ascii[3:0] + 4'd9 :
                 4'd0;
    end

endmodule

// File: rtl/hex_line_parser.sv
// hex_line_parser: assembles ASCII hex lines into words and hands them out over valid/ready
module hex_line_parser
    import hex_line_parser_pkg::*;
#(
    parameter int NDIGITS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             rx_ready,
    output logic [4*NDIGITS-1:0]             out_value,
    output logic [$clog2(NDIGITS+1)-1:0]     out_ndigits,
    output logic                             out_err,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(NDIGITS + 1);

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [W-1:0]  out_value_q, out_value_d;
    logic [CW-1:0] out_ndigits_q, out_ndigits_d;
    logic          out_err_q, out_err_d;
    logic          out_valid_q, out_valid_d;

    logic [3:0]    nibble;
    byte_class_t   cls;
    logic          rx_fire;
    logic          cnt_full;

    ascii_to_hex u_ascii_to_hex (
        .ascii  (rx_data),
        .nibble (nibble)
    );

    assign cls         = classify(rx_data);
    assign rx_ready    = (state_q != ST_EMIT);
    assign rx_fire     = rx_valid && rx_ready;
    assign cnt_full    = (cnt_q == CW'(NDIGITS));
    assign out_value   = out_value_q;
    assign out_ndigits = out_ndigits_q;
    assign out_err     = out_err_q;
    assign out_valid   = out_valid_q;

    // State, accumulator and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            out_value_q   <= '0;
            out_ndigits_q <= '0;
            out_err_q     <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            out_value_q   <= out_value_d;
            out_ndigits_q <= out_ndigits_d;
            out_err_q     <= out_err_d;
            out_valid_q   <= out_valid_d;
        end
    end

    // Next state: a bad byte or an overflowing digit poisons the line until its terminator
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (rx_fire) state_d = (cls == CLS_HEX) ? ST_ACCUM :
                                               (cls == CLS_BAD) ? ST_DISCARD : ST_IDLE;
            ST_ACCUM:   if (rx_fire) state_d = (cls == CLS_BAD || (cls == CLS_HEX && cnt_full)) ? ST_DISCARD :
                                               (cls == CLS_TERM) ? ST_EMIT : ST_ACCUM;
            ST_DISCARD: if (rx_fire && cls == CLS_TERM) state_d = ST_EMIT;
            default:    if (out_ready) state_d = ST_IDLE;
        endcase
    end

    // Datapath: shift digits in, load the result on a terminator, clear on transfer
    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        out_value_d   = out_value_q;
        out_ndigits_d = out_ndigits_q;
        out_err_d     = out_err_q;
        out_valid_d   = (state_d == ST_EMIT);
        if (state_q == ST_EMIT) begin
            if (out_ready) begin
                acc_d = '0;
                cnt_d = '0;
                err_d = 1'b0;
            end
        end else if (rx_fire) begin
            if (cls == CLS_HEX && state_q != ST_DISCARD) begin
                if (cnt_full) begin
                    err_d = 1'b1;
                end else begin
                    acc_d = (acc_q << 4) | W'(nibble);
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (cls == CLS_BAD)
                err_d = 1'b1;
            if (cls == CLS_TERM && state_q == ST_ACCUM) begin
                out_value_d   = acc_q;
                out_ndigits_d = cnt_q;
                out_err_d     = 1'b0;
            end
            if (cls == CLS_TERM && state_q == ST_DISCARD) begin
                out_value_d   = '0;
                out_ndigits_d = '0;
                out_err_d     = err_q;
            end
        end
    end

endmodule

// File: tb/tb_hex_line_parser.sv
// tb_hex_line_parser: scoreboard bench driving directed ASCII lines into hex_line_parser
module tb_hex_line_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [31:0] out_value;
    logic [3:0]  out_ndigits;
    logic        out_err;
    logic        out_valid;
    logic        out_ready = 1'b1;

    typedef struct packed {
        logic [31:0] v;
        logic [3:0]  n;
        logic        e;
    } res_t;

    res_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          valid_cycles = 0;
    int          rdy_low = 0;

    hex_line_parser #(.NDIGITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .out_value   (out_value),
        .out_ndigits (out_ndigits),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        if (!rx_ready) rdy_low++;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_ready_timeout: byte 0x%0h not accepted after %0d cycles", b, n);
        end
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
        rx_valid = 1'b0;
    endtask

    // Monitor: pop on the first cycle of each result, then require it to stay frozen
    initial begin
        logic [36:0] snap;
        logic        held;
        res_t        e;
        held = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                held = 1'b0;
            end else begin
                valid_cycles++;
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got value 0x%0h ndigits %0d err %0b, expected none",
                                 out_value, out_ndigits, out_err);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_value", out_value, e.v);
                        chk("out_ndigits", out_ndigits, e.n);
                        chk("out_err", out_err, e.e);
                    end
                    snap = {out_value, out_ndigits, out_err};
                    held = 1'b1;
                end else begin
                    chk("hold_stable", {out_value, out_ndigits, out_err}, snap);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int r0;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_ndigits", out_ndigits, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_rx_ready", rx_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // "1A3f\r": single result, valid exactly one cycle, starting right after the CR
        v0 = valid_cycles;
        exp_q.push_back(res_t'{32'h00001A3F, 4'd4, 1'b0});
        send_str("1A3f\r");
        chk("t1_valid_first", out_valid, 1);
        chk("t1_rx_ready_emit", rx_ready, 0);
        @(negedge clk);
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_rx_ready_back", rx_ready, 1);
        chk("t1_valid_cycles", valid_cycles - v0, 1);

        // full-width line, CR-LF, then an overflowing line
        exp_q.push_back(res_t'{32'h12345678, 4'd8, 1'b0});
        exp_q.push_back(res_t'{32'h00000000, 4'd0, 1'b1});
        send_str("12345678\r\n123456789\r");
        repeat (2) @(negedge clk);

        // bad character line followed by a clean lowercase line
        exp_q.push_back(res_t'{32'h00000000, 4'd0, 1'b1});
        exp_q.push_back(res_t'{32'h000000FF, 4'd2, 1'b0});
        send_str("12G4\nff\n");
        repeat (2) @(negedge clk);

        // backpressure: hold 5 cycles while the next line is already offered
        #1 out_ready = 1'b0;
        exp_q.push_back(res_t'{32'h000000AB, 4'd2, 1'b0});
        exp_q.push_back(res_t'{32'h0000000C, 4'd1, 1'b0});
        send_str("A B\r");
        fork
            begin
                chk("t4_stall_valid", out_valid, 1);
                chk("t4_stall_rx_ready", rx_ready, 0);
                repeat (4) begin
                    @(negedge clk);
                    chk("t4_stall_valid", out_valid, 1);
                    chk("t4_stall_rx_ready", rx_ready, 0);
                    chk("t4_stall_value", out_value, 32'hAB);
                end
                #1 out_ready = 1'b1;
            end
            send_str("C\r");
        join
        repeat (2) @(negedge clk);

        // empty lines: no result, never stalls
        v0 = valid_cycles;
        r0 = rdy_low;
        send_str("\r\n\r\n");
        repeat (3) @(negedge clk);
        chk("t5_no_valid", valid_cycles - v0, 0);
        chk("t5_rx_ready_low", rdy_low - r0, 0);

        // reset mid-line drops the partial value
        send_str("5A");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_value", out_value, 0);
        chk("t6_rst_out_ndigits", out_ndigits, 0);
        chk("t6_rst_out_err", out_err, 0);
        chk("t6_rst_rx_ready", rx_ready, 1);
        exp_q.push_back(res_t'{32'h00000007, 4'd1, 1'b0});
        send_str("7\r");
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
